// File: rtl/twiddle_fetch_ctrl.sv
// twiddle_fetch_ctrl
//   Sequencer for a 2^QW-entry quarter-wave sine ROM with a 1-cycle registered read.
//   It takes one full-circle phase index per request and issues two reads through the
//   single ROM port, first sin and then cos. It folds the quarter-wave symmetry
//   (address mirror plus negation) and returns signed DW-bit sin/cos over valid/ready.
//
// Ports
//   clk, rst          : clock and asynchronous active-high reset
//   in_valid/in_ready : phase request handshake; in_phase is the full-circle index
//   rom_addr/rom_data : ROM read port; data arrives the cycle after its address
//   out_valid/out_ready, out_sin, out_cos : result handshake and signed twiddles
//
// Sequence: IDLE -> ADDR_S -> ADDR_C -> WAIT_C -> OUT -> IDLE. This is one request
// every 5 clk when out_ready is held high.
module twiddle_fetch_ctrl #(
    parameter int QW = 6,
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [QW+1:0]        in_phase,
    output logic [AW-1:0]        rom_addr,
    input  logic [DW-1:0]        rom_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_sin,
    output logic signed [DW-1:0] out_cos
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR_S = 3'd1,
        ADDR_C = 3'd2,
        WAIT_C = 3'd3,
        OUT    = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [AW-1:0]         r_rom_addr;
    logic [QW+1:0]         r_phase;
    logic                  r_sin_neg;
    logic signed [DW-1:0]  r_sin;
    logic signed [DW-1:0]  r_cos;
    logic [QW+1:0]         w_cos_phase;

    // cos(p) = sin(p + quarter turn). The add wraps naturally at QW+2 bits.
    assign w_cos_phase = r_phase + {2'b01, {QW{1'b0}}};

    // Odd quadrants read the table backwards. 2^QW-1-i is simply ~i.
    // The upper address bits are zero-extended.
    function automatic logic [AW-1:0] f_addr(input logic [QW+1:0] x);
        logic [QW-1:0] idx;
        idx = x[QW] ? ~x[QW-1:0] : x[QW-1:0];
        return AW'(idx);
    endfunction

    // The lower half-circle is negated. ROM entries never exceed 2^(DW-1)-1, so this cannot overflow.
    function automatic logic [DW-1:0] f_sign(input logic [DW-1:0] d, input logic neg);
        return neg ? (~d + DW'(1)) : d;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_rom_addr  <= '0;
            r_phase     <= '0;
            r_sin_neg   <= 1'b0;
            r_sin       <= '0;
            r_cos       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // The sin address is registered on the accept edge.
                        // The ROM therefore sees it throughout ADDR_S.
                        r_phase    <= in_phase;
                        r_rom_addr <= f_addr(in_phase);
                        r_in_ready <= 1'b0;
                        r_state    <= ADDR_S;
                    end
                end
                ADDR_S: begin
                    r_rom_addr <= f_addr(w_cos_phase);
                    r_sin_neg  <= r_phase[QW+1];
                    r_state    <= ADDR_C;
                end
                ADDR_C: begin
                    // The sin word sampled by the ROM at the end of ADDR_S is on rom_data now.
                    r_sin   <= f_sign(rom_data, r_sin_neg);
                    r_state <= WAIT_C;
                end
                WAIT_C: begin
                    r_cos       <= f_sign(rom_data, w_cos_phase[QW+1]);
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign rom_addr  = r_rom_addr;
    assign out_sin   = r_sin;
    assign out_cos   = r_cos;

endmodule

// File: tb/tb_twiddle_fetch_ctrl.sv
module tb_twiddle_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_phase;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic       out_valid;
    logic       out_ready;
    logic signed [7:0] out_sin;
    logic signed [7:0] out_cos;

    twiddle_fetch_ctrl #(.QW(6), .DW(8), .AW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_phase  (in_phase),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sin   (out_sin),
        .out_cos   (out_cos)
    );

    always #5 clk = ~clk;

    // Every entry is distinct, so any wrong mirror shows up in the data.
    // rom[i] = 2i+2, except rom[63] = 127. This gives rom[0] = 0x02 and rom[63] = 0x7F.
    logic [7:0] rom [64];
    always @(posedge clk) rom_data <= rom[rom_addr[5:0]];

    int cyc = 0;
    int hs  = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (out_valid && out_ready) hs <= hs + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] x);
        logic [7:0] v;
        logic [5:0] i;
        i = x[6] ? 6'(63 - x[5:0]) : x[5:0];
        v = rom[i];
        return x[7] ? 8'(8'd0 - v) : v;
    endfunction

    // Issues a request at a negedge. a0 and a1 are rom_addr after the 1st and 2nd edges.
    // The accept edge counts as the 1st. lat is the edge count (accept = 1) at which out_valid is seen.
    task automatic do_req(input logic [7:0] p, input bit hold,
                          output logic [7:0] s, output logic [7:0] c,
                          output logic [7:0] a0, output logic [7:0] a1,
                          output int lat, output int acc);
        int n;
        in_phase = p;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", {31'd0, in_ready}, 32'd1);
        acc = cyc;
        @(negedge clk);
        a0 = rom_addr;
        in_phase = ~p;              // must be ignored while busy
        if (!hold) in_valid = 1'b0;
        @(negedge clk);
        a1 = rom_addr;
        lat = 2;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        s = out_sin;
        c = out_cos;
    endtask

    typedef struct {
        logic [7:0] p;
        logic [7:0] s;
        logic [7:0] c;
        logic [7:0] a0;
        logic [7:0] a1;
    } vec_t;

    vec_t vt [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] s, c, a0, a1, s0, c0;
        int lat, acc, prev_acc, errs, h0, n;

        for (int i = 0; i < 64; i++) rom[i] = (i == 63) ? 8'd127 : 8'(2 * i + 2);

        vt[0] = '{8'h00, 8'h02, 8'h7F, 8'h00, 8'h3F};
        vt[1] = '{8'h40, 8'h7F, 8'hFE, 8'h3F, 8'h00};
        vt[2] = '{8'h80, 8'hFE, 8'h81, 8'h00, 8'h3F};
        vt[3] = '{8'hFF, 8'hFE, 8'h7F, 8'h00, 8'h3F};   // cos wraps 255+64 -> 63
        vt[4] = '{8'h10, 8'h22, 8'h60, 8'h10, 8'h2F};
        vt[5] = '{8'hC5, 8'h8A, 8'h0C, 8'h3A, 8'h05};

        rst = 1'b1; in_valid = 1'b0; in_phase = 8'h00; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sin", {24'd0, out_sin}, 32'd0);
        chk("rst_cos", {24'd0, out_cos}, 32'd0);
        chk("rst_addr", {24'd0, rom_addr}, 32'd0);

        // directed vectors
        for (int k = 0; k < 6; k++) begin
            do_req(vt[k].p, 1'b0, s, c, a0, a1, lat, acc);
            chk($sformatf("vec%0d_sin", k), {24'd0, s}, {24'd0, vt[k].s});
            chk($sformatf("vec%0d_cos", k), {24'd0, c}, {24'd0, vt[k].c});
            chk($sformatf("vec%0d_a0", k), {24'd0, a0}, {24'd0, vt[k].a0});
            chk($sformatf("vec%0d_a1", k), {24'd0, a1}, {24'd0, vt[k].a1});
            chk($sformatf("vec%0d_lat", k), lat, 32'd4);
            @(negedge clk);
            chk($sformatf("vec%0d_hs_idle", k), {30'd0, out_valid, in_ready}, 32'd1);
        end

        // abort in ADDR_C with reset
        in_phase = 8'h20; in_valid = 1'b1;
        @(negedge clk);             // accepted; now ADDR_S
        in_valid = 1'b0;
        @(negedge clk);             // ADDR_C
        chk("abort_pre_addr", {24'd0, rom_addr}, 32'h1F);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_addr", {24'd0, rom_addr}, 32'd0);
        chk("abort_sin", {24'd0, out_sin}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        errs = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0) errs++;
        end
        chk("abort_no_output", errs, 32'd0);
        do_req(8'h10, 1'b0, s, c, a0, a1, lat, acc);
        chk("post_abort_sin", {24'd0, s}, 32'h22);
        chk("post_abort_cos", {24'd0, c}, 32'h60);
        chk("post_abort_lat", lat, 32'd4);
        @(negedge clk);

        // backpressure: hold OUT for 20 clk while in_valid stays high
        out_ready = 1'b0;
        do_req(8'hC5, 1'b1, s0, c0, a0, a1, lat, acc);
        chk("bp_sin", {24'd0, s0}, 32'h8A);
        chk("bp_cos", {24'd0, c0}, 32'h0C);
        h0 = hs;
        errs = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sin !== s0 || out_cos !== c0) errs++;
            in_phase = 8'($urandom);
        end
        chk("bp_stable", errs, 32'd0);
        chk("bp_no_hs", hs - h0, 32'd0);
        out_ready = 1'b1;
        in_phase  = 8'h40;
        @(negedge clk);             // handshake done, now IDLE with in_valid high
        chk("bp_one_hs", hs - h0, 32'd1);
        chk("bp_idle", {30'd0, out_valid, in_ready}, 32'd1);
        @(negedge clk);             // next request accepted
        chk("bp_next_addr", {24'd0, rom_addr}, 32'h3F);
        chk("bp_next_busy", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_next_sin", {24'd0, out_sin}, 32'h7F);
        chk("bp_next_cos", {24'd0, out_cos}, 32'hFE);
        @(negedge clk);

        // full sweep back to back; one result every 5 clk
        prev_acc = 0;
        errs = 0;
        for (int p = 0; p < 256; p++) begin
            do_req(8'(p), 1'b1, s, c, a0, a1, lat, acc);
            if (s !== model(8'(p)) || c !== model(8'(p + 64))) begin
                errs++;
                if (errs < 4)
                    $display("FAIL sweep p=%0h: got %0h/%0h want %0h/%0h",
                             p, s, c, model(8'(p)), model(8'(p + 64)));
            end
            if (p > 0) chk("sweep_period", acc - prev_acc, 32'd5);
            prev_acc = acc;
        end
        in_valid = 1'b0;
        chk("sweep_data", errs, 32'd0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
